fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Read-domain pointer/flag controller of the async FIFO, clocked by clk_out.
//  Consumes the write pointer (Gray, DEPTH-bit address + wrap bit) after it
//  has crossed into clk_out through the 2-flop synchronizer stage.
//  Produces the RAM read address, the registered empty / almost-empty flags,
//  the fill level, a read-valid strobe and the Gray read pointer that is
//  returned to the write domain.
// PARAMETERS
//  DEPTH      8  FIFO entries; power of two, >= 4
//  AE_THRESH  2  rd_almost_empty asserts when level <= AE_THRESH (0..DEPTH)
//  W          $clog2(DEPTH) localparam; pointers are W+1 bits wide
// PORTS
//  clk_out          in   1    read-domain clock
//  rst_n            in   1    asynchronous, active-low reset
//  rd_en            in   1    read request from the consumer
//  clr_underflow    in   1    clears sticky rd_underflow
//  wptr_gray_sync   in   W+1  synchronized Gray write pointer
//  rptr_gray        out  W+1  registered Gray read pointer, to the wr-domain sync
//  rd_addr          out  W    RAM read address = rbin[W-1:0]
//  rd_empty         out  1    registered empty flag
//  rd_almost_empty  out  1    registered, level <= AE_THRESH
//  rd_level         out  W+1  registered fill level, 0..DEPTH
//  rd_valid         out  1    1-cycle strobe: RAM data for accepted read valid
//  rd_underflow     out  1    sticky: rd_en seen while rd_empty
// BEHAVIOUR
//  - Reset (async, rst_n=0): rbin=0, rptr_gray=0, rd_empty=1,
//    rd_almost_empty=1, rd_level=0, rd_valid=0, rd_underflow=0.
//    Mid-operation reset takes effect immediately; pending reads are dropped.
//  - rd_fire = rd_en & ~rd_empty. rbin_next = rbin + rd_fire, W+1 bit,
//    natural wrap mod 2*DEPTH. Reads while empty are ignored (no pointer move).
//  - rptr_gray <= rbin_next ^ (rbin_next >> 1); every output is a flop.
//  - rd_empty <= (gray(rbin_next) == wptr_gray_sync). The last read sets empty
//    on the same edge the pointer advances, so there is no over-read.
//  - wbin = Gray-to-binary(wptr_gray_sync) (XOR prefix from MSB).
//    rd_level <= (wbin - rbin_next) mod 2^(W+1); rd_almost_empty <=
//    (level_next <= AE_THRESH). Level is conservative (lags writes).
//  - Latency: wptr_gray_sync change at edge N -> flags/level update at N+1.
//    rd_addr is valid for the cycle rd_fire is high; rd_valid <= rd_fire
//    (aligned with a registered-output RAM, 1-cycle read latency).
//  - rd_underflow <= 1 on (rd_en & rd_empty); clr_underflow clears it.
//    Set wins over clear when both occur in the same cycle.
//  - wptr_gray_sync changing in the same cycle as rd_fire: both are used in
//    that cycle's next-state computation; no event is lost.
// TESTING (DEPTH=8, W=3, AE_THRESH=2)
//  1 Reset, rd_en=1, wptr=0 -> rd_empty=1, rbin stays 0, rd_valid=0,
//    rd_underflow=1 next edge; clr_underflow=1 -> 0 next edge.
//  2 wptr_gray_sync=4'b0010 (bin 3) -> next edge rd_empty=0, rd_level=3,
//    rd_almost_empty=0; 3 back-to-back reads -> rd_addr 0,1,2, rd_valid 3 pulses
//    delayed 1 cycle, level 2,1,0, rd_empty=1 on 3rd edge, rptr_gray=4'b0010.
//  3 Full lap: wptr=4'b1100 (bin 8), rbin=0 -> rd_level=8; 8 reads ->
//    rd_addr wraps 7->0, rptr_gray=4'b1100, rd_empty=1; repeat to bin 16 -> 0.
//  4 Read accepted in the same cycle wptr advances 3->4 with rbin=2 ->
//    rbin=3, rd_level=1, rd_almost_empty=1, rd_empty=0.
//  5 rd_en while empty in the same cycle as clr_underflow=1 -> rd_underflow
//    stays 1.
//  6 Assert rst_n=0 mid-burst at level 5 -> all outputs return to reset values
//    asynchronously, before the next clk_out edge.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-domain pointer and flag controller of the async FIFO.
// Every output is a flop; flags and level are computed from the next read pointer.
module fifo_read_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned W        = $clog2(DEPTH)
) (
    input  logic         clk_out,
    input  logic         rst_n,
    input  logic         rd_en,
    input  logic         clr_underflow,
    input  logic [W:0]   wptr_gray_sync,
    output logic [W:0]   rptr_gray,
    output logic [W-1:0] rd_addr,
    output logic         rd_empty,
    output logic         rd_almost_empty,
    output logic [W:0]   rd_level,
    output logic         rd_valid,
    output logic         rd_underflow
);

    logic [W:0] rbin_q, rbin_d;
    logic [W:0] rptr_gray_q, rptr_gray_d;
    logic [W:0] rd_level_q, rd_level_d;
    logic       rd_empty_q, rd_empty_d;
    logic       rd_ae_q, rd_ae_d;
    logic       rd_valid_q, rd_valid_d;
    logic       rd_underflow_q, rd_underflow_d;
    logic       rd_fire;
    logic [W:0] wbin;

    always_comb begin
        rd_fire = rd_en & ~rd_empty_q;
        rbin_d  = rbin_q + (W+1)'(rd_fire);
        rptr_gray_d = rbin_d ^ (rbin_d >> 1);

        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        wbin = '0;
        for (int i = 0; i <= W; i++) begin
            wbin[i] = ^(wptr_gray_sync >> i);
        end

        rd_level_d     = wbin - rbin_d;
        rd_empty_d     = (rptr_gray_d == wptr_gray_sync);
        rd_ae_d        = (32'(rd_level_d) <= AE_THRESH);
        rd_valid_d     = rd_fire;
        rd_underflow_d = (rd_en & rd_empty_q) | (rd_underflow_q & ~clr_underflow);
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            rbin_q         <= '0;
            rptr_gray_q    <= '0;
            rd_level_q     <= '0;
            rd_empty_q     <= 1'b1;
            rd_ae_q        <= 1'b1;
            rd_valid_q     <= 1'b0;
            rd_underflow_q <= 1'b0;
        end else begin
            rbin_q         <= rbin_d;
            rptr_gray_q    <= rptr_gray_d;
            rd_level_q     <= rd_level_d;
            rd_empty_q     <= rd_empty_d;
            rd_ae_q        <= rd_ae_d;
            rd_valid_q     <= rd_valid_d;
            rd_underflow_q <= rd_underflow_d;
        end
    end

    assign rptr_gray       = rptr_gray_q;
    assign rd_addr         = rbin_q[W-1:0];
    assign rd_empty        = rd_empty_q;
    assign rd_almost_empty = rd_ae_q;
    assign rd_level        = rd_level_q;
    assign rd_valid        = rd_valid_q;
    assign rd_underflow    = rd_underflow_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: counting model of reads/writes, directed pins plus random traffic.
module tb_fifo_read_ctrl;

    localparam int DEPTH = 8;
    localparam int W     = 3;
    localparam int MOD   = 2 * DEPTH;

    logic         clk_out = 1'b0;
    logic         rst_n   = 1'b1;
    logic         rd_en   = 1'b0;
    logic         clr_underflow = 1'b0;
    logic [W:0]   wptr_gray_sync;
    logic [W:0]   rptr_gray;
    logic [W-1:0] rd_addr;
    logic         rd_empty, rd_almost_empty, rd_valid, rd_underflow;
    logic [W:0]   rd_level;

    int total = 0;
    int bad   = 0;
    int wcnt  = 0;    // writes published so far (unbounded integer)
    bit chk_en = 1'b0;

    // Model state: reads accepted (mod 2*DEPTH) and the expected registered outputs.
    int m_reads = 0;
    int m_level = 0;
    bit m_empty = 1'b1, m_ae = 1'b1, m_valid = 1'b0, m_uf = 1'b0;

    fifo_read_ctrl #(.DEPTH(DEPTH), .AE_THRESH(2)) dut (
        .clk_out         (clk_out),
        .rst_n           (rst_n),
        .rd_en           (rd_en),
        .clr_underflow   (clr_underflow),
        .wptr_gray_sync  (wptr_gray_sync),
        .rptr_gray       (rptr_gray),
        .rd_addr         (rd_addr),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_level        (rd_level),
        .rd_valid        (rd_valid),
        .rd_underflow    (rd_underflow)
    );

    always #5 clk_out = ~clk_out;

    function automatic logic [W:0] gray(input int n);
        logic [W:0] b;
        b = n[W:0];
        return b ^ (b >> 1);
    endfunction

    assign wptr_gray_sync = gray(wcnt % MOD);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            m_reads = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1;
            m_valid = 1'b0; m_uf = 1'b0;
        end else begin
            bit fire;
            fire    = rd_en && !m_empty;
            m_uf    = (rd_en && m_empty) || (m_uf && !clr_underflow);
            m_valid = fire;
            m_reads = (m_reads + int'(fire)) % MOD;
            m_level = (wcnt - m_reads) & (MOD - 1);
            m_empty = (m_level == 0);
            m_ae    = (m_level <= 2);
        end
    end

    // Single compare process, sampling on the falling edge.
    always @(negedge clk_out) begin
        if (chk_en) begin
            chk("level",     int'(rd_level),        m_level);
            chk("empty",     int'(rd_empty),        int'(m_empty));
            chk("aempty",    int'(rd_almost_empty), int'(m_ae));
            chk("valid",     int'(rd_valid),        int'(m_valid));
            chk("underflow", int'(rd_underflow),    int'(m_uf));
            chk("rptr_gray", int'(rptr_gray),       int'(gray(m_reads)));
            chk("rd_addr",   int'(rd_addr),         m_reads % DEPTH);
        end
    end

    task automatic step();
        @(posedge clk_out);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("pin_rst_empty", int'(rd_empty), 1);
        chk("pin_rst_level", int'(rd_level), 0);

        // Read while empty: underflow sets, pointer stays.
        rd_en = 1'b1;
        step();
        chk("pin_uf_set", int'(rd_underflow), 1);
        chk("pin_uf_addr", int'(rd_addr), 0);
        rd_en = 1'b0; clr_underflow = 1'b1;
        step();
        chk("pin_uf_clr", int'(rd_underflow), 0);
        clr_underflow = 1'b0;

        // Three writes visible, then three back-to-back reads.
        wcnt = 3;
        step();
        chk("pin_lvl3", int'(rd_level), 3);
        chk("pin_ae0", int'(rd_almost_empty), 0);
        rd_en = 1'b1;
        chk("pin_addr0", int'(rd_addr), 0);
        step();
        chk("pin_lvl2", int'(rd_level), 2);
        step();
        chk("pin_lvl1", int'(rd_level), 1);
        step();
        chk("pin_empty3", int'(rd_empty), 1);
        chk("pin_rptr3", int'(rptr_gray), 4'b0010);
        chk("pin_valid3", int'(rd_valid), 1);
        rd_en = 1'b0;
        step();
        chk("pin_valid_off", int'(rd_valid), 0);

        // Read accepted while the write pointer advances in the same cycle.
        wcnt = 5; step();
        rd_en = 1'b1; step();
        wcnt = 6; step();
        chk("pin_same_lvl", int'(rd_level), 1);
        chk("pin_same_ae", int'(rd_almost_empty), 1);
        chk("pin_same_empty", int'(rd_empty), 0);
        chk("pin_same_rptr", int'(rptr_gray), 4'b0111);
        step();
        rd_en = 1'b0;

        // Two full laps of eight.
        for (int lap = 0; lap < 2; lap++) begin
            wcnt += DEPTH;
            step();
            chk("pin_full_lvl", int'(rd_level), DEPTH);
            rd_en = 1'b1;
            repeat (DEPTH) step();
            rd_en = 1'b0;
            chk("pin_lap_empty", int'(rd_empty), 1);
        end

        // Set wins over clear.
        rd_en = 1'b1; step();
        clr_underflow = 1'b1; step();
        chk("pin_uf_setwins", int'(rd_underflow), 1);
        rd_en = 1'b0; step();
        clr_underflow = 1'b0;
        chk("pin_uf_cleared", int'(rd_underflow), 0);

        // Asynchronous reset mid-burst.
        wcnt += 5; step();
        chk("pin_lvl5", int'(rd_level), 5);
        rd_en = 1'b1;
        #2 rst_n = 1'b0; wcnt = 0;
        #1;
        chk("pin_ar_level", int'(rd_level), 0);
        chk("pin_ar_empty", int'(rd_empty), 1);
        chk("pin_ar_ae", int'(rd_almost_empty), 1);
        chk("pin_ar_valid", int'(rd_valid), 0);
        chk("pin_ar_rptr", int'(rptr_gray), 0);
        chk("pin_ar_uf", int'(rd_underflow), 0);
        rd_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Random traffic; writes never run more than DEPTH ahead of reads.
        for (int n = 0; n < 3000; n++) begin
            rd_en = ($urandom % 4) != 0;
            clr_underflow = ($urandom % 8) == 0;
            if ((((wcnt - m_reads) & (MOD - 1)) < DEPTH) && ($urandom % 2 == 1)) wcnt++;
            if ($urandom % 600 == 0) begin
                rst_n = 1'b0; wcnt = 0;
                step();
                rst_n = 1'b1;
            end
            step();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
